// File: rtl/alu_issue_stage.sv
// Decode/issue stage in front of the ALU: operand read, immediate select, distance-1
// forwarding from the ALU result, load-use bubbling, stall and flush handling.
module alu_issue_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int IMM_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       instr,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [REG_AW-1:0] rs_addr,
  output logic [REG_AW-1:0] rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_ctl,
  output logic              out_valid,
  output logic [REG_AW-1:0] out_rd,
  output logic              illegal
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_BEQ  = 4'h6;
  localparam logic [3:0] OP_BNE  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_LW   = 4'h9;
  localparam logic [3:0] OP_ADDI = 4'hD;
  localparam logic [3:0] OP_ILL  = 4'hF;

  typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_t;

  state_t state, state_nxt;

  function automatic logic signed [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

  // r0 always reads zero; otherwise the in-flight ALU result wins over stale regfile data.
  function automatic logic signed [DATA_W-1:0] sel_opnd(
    input logic [REG_AW-1:0]        addr,
    input logic signed [DATA_W-1:0] rf_val,
    input logic signed [DATA_W-1:0] fwd_val,
    input logic                     fwd
  );
    if (addr == '0) return '0;
    if (fwd) return fwd_val;
    return rf_val;
  endfunction

  logic [3:0]               op_p0;
  logic [REG_AW-1:0]        rd_p0, rs_p0, rt_p0;
  logic                     imm_form_p0, writer_p0, nop_p0;
  logic                     fwd_rs_p0, fwd_rt_p0, load_use_hit, accept;
  logic signed [DATA_W-1:0] a_p0, b_p0;
  logic [3:0]               ctl_p0;
  logic [REG_AW-1:0]        wrd_p0;

  logic signed [DATA_W-1:0] a_p1, b_p1;
  logic [3:0]               ctl_p1;
  logic [REG_AW-1:0]        rd_p1;
  logic                     vld_p1, lw_p1, ill_p1;

  // ---- p0: decode, operand select, hazard detection ----
  assign op_p0   = instr[15:12];
  assign rd_p0   = instr[11:8];
  assign rs_p0   = instr[7:4];
  assign rt_p0   = instr[3:0];
  assign rs_addr = rs_p0;
  assign rt_addr = rt_p0;

  assign imm_form_p0 = (op_p0 == OP_LW) || (op_p0 == OP_ADDI);
  assign nop_p0      = (op_p0 == OP_NOP) || (op_p0 == OP_ILL);
  assign writer_p0   = !(nop_p0 || op_p0 == OP_BEQ || op_p0 == OP_BNE || op_p0 == OP_JMP);

  // A load's result is not on alu_result yet, so it is never a forwarding source.
  assign fwd_rs_p0 = vld_p1 && !lw_p1 && (rd_p1 != '0) && (rd_p1 == rs_p0);
  assign fwd_rt_p0 = vld_p1 && !lw_p1 && (rd_p1 != '0) && (rd_p1 == rt_p0);

  assign load_use_hit = in_valid && lw_p1 && (rd_p1 != '0) &&
                        ((rs_p0 == rd_p1) || (!imm_form_p0 && (rt_p0 == rd_p1)));

  assign a_p0   = nop_p0 ? '0 : sel_opnd(rs_p0, signed'(rs_data), signed'(alu_result), fwd_rs_p0);
  assign b_p0   = nop_p0      ? '0 :
                  imm_form_p0 ? sext_imm(instr[IMM_W-1:0]) :
                                sel_opnd(rt_p0, signed'(rt_data), signed'(alu_result), fwd_rt_p0);
  assign ctl_p0 = nop_p0 ? 4'h0 : op_p0;
  assign wrd_p0 = writer_p0 ? rd_p0 : '0;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = RUN;
    end else if (!stall) begin
      case (state)
        RUN:     if (load_use_hit) state_nxt = BUBBLE;
        BUBBLE:  state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    in_ready = !stall && !flush && (state == RUN) && !load_use_hit;
  end

  // ---- p1: issue registers feeding the ALU ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p1   <= '0;
      b_p1   <= '0;
      ctl_p1 <= 4'h0;
      rd_p1  <= '0;
      vld_p1 <= 1'b0;
      lw_p1  <= 1'b0;
      ill_p1 <= 1'b0;
    end else if (flush) begin
      a_p1   <= '0;
      b_p1   <= '0;
      ctl_p1 <= 4'h0;
      rd_p1  <= '0;
      vld_p1 <= 1'b0;
      lw_p1  <= 1'b0;
      ill_p1 <= 1'b0;
    end else if (stall) begin
      ill_p1 <= 1'b0;
    end else if (accept) begin
      a_p1   <= a_p0;
      b_p1   <= b_p0;
      ctl_p1 <= ctl_p0;
      rd_p1  <= wrd_p0;
      vld_p1 <= !nop_p0;
      lw_p1  <= (op_p0 == OP_LW);
      ill_p1 <= (op_p0 == OP_ILL);
    end else begin
      a_p1   <= '0;
      b_p1   <= '0;
      ctl_p1 <= 4'h0;
      rd_p1  <= '0;
      vld_p1 <= 1'b0;
      lw_p1  <= 1'b0;
      ill_p1 <= 1'b0;
    end
  end

  assign alu_a     = a_p1;
  assign alu_b     = b_p1;
  assign alu_ctl   = ctl_p1;
  assign out_rd    = rd_p1;
  assign out_valid = vld_p1;
  assign illegal   = ill_p1;

endmodule
